rr_grant_indexer: RTL

//   Round-robin arbiter for 8 requesters. Produces a registered 3-bit grant index plus a valid flag.

---
 rtl/arb_pkg.sv | 17 +
 rtl/rr_grant_indexer_if.sv | 23 ++
 rtl/dec3x8.sv | 10 +
 rtl/rr_pick8.sv | 33 +++
 rtl/rr_grant_indexer.sv | 106 ++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared constants and types for the round-robin grant indexer.
package arb_pkg;

  localparam int IDX_W = 3;
  localparam int N_REQ = 2 ** IDX_W;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Next requester index after idx, wrapping 7 -> 0.
  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/rr_grant_indexer_if.sv
// Request/grant bundle between requesters and the arbiter.
interface rr_grant_indexer_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             grant_expired;

  // Requester side: drives requests and release, observes the grant.
  modport master (
    output req, done,
    input  grant_idx, grant_valid, grant_expired
  );

  // Arbiter side.
  modport slave (
    input  req, done,
    output grant_idx, grant_valid, grant_expired
  );

endinterface

// File: rtl/dec3x8.sv
// 3-to-8 binary decoder fed by grant_idx.
module dec3x8 (
  input  logic [2:0] a,
  output logic [7:0] y
);

  // One output bit per index value.
  always_comb y = 8'b0000_0001 << a;

endmodule

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: rotate so ptr sits at bit 0,
// take the lowest set bit, then rotate the winning offset back.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] pick,
  output logic             any_req
);

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] ofs;

  // rot[gi] is the requester gi places after ptr (mod 8).
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    logic [IDX_W-1:0] src;
    assign src     = ptr + IDX_W'(gi);
    assign rot[gi] = req[src];
  end

  // Fixed-priority scan: lowest rotated position wins.
  always_comb begin
    ofs = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) ofs = IDX_W'(i);
    end
  end

  assign pick    = ptr + ofs;
  assign any_req = |req;

endmodule

// File: rtl/rr_grant_indexer.sv
// Round-robin arbiter for 8 requesters with hold limit and registered
// grant index / valid / expired outputs.
module rr_grant_indexer
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_grant_indexer_if.slave  bus
);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] ptr_reg, ptr_next;
  logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [IDX_W-1:0] grant_idx_reg, grant_idx_next;
  logic             grant_valid_reg, grant_valid_next;
  logic             grant_expired_reg, grant_expired_next;

  logic             rel_done, rel_drop, rel_to, rel;
  logic [IDX_W-1:0] pick_ptr, pick;
  logic             any_req;

  // Release causes for the current grant; only meaningful in GRANT.
  always_comb begin
    rel_done = bus.done;
    rel_drop = ~bus.req[grant_idx_reg];
    rel_to   = (hold_cnt_reg == CNT_W'(HOLD_MAX - 1));
    rel      = (state_reg == ST_GRANT) && (rel_done || rel_drop || rel_to);
    // On release the search must already start past the released owner.
    pick_ptr = rel ? idx_inc(grant_idx_reg) : ptr_reg;
  end

  rr_pick8 u_pick (
    .req     (bus.req),
    .ptr     (pick_ptr),
    .pick    (pick),
    .any_req (any_req)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_next         = state_reg;
    ptr_next           = ptr_reg;
    hold_cnt_next      = hold_cnt_reg;
    grant_idx_next     = grant_idx_reg;
    grant_valid_next   = grant_valid_reg;
    grant_expired_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (any_req) begin
          grant_idx_next   = pick;
          grant_valid_next = 1'b1;
          hold_cnt_next    = '0;
          state_next       = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (rel) begin
          ptr_next           = idx_inc(grant_idx_reg);
          // Expiry is flagged only when the limit alone ended the tenure.
          grant_expired_next = rel_to && !rel_done && !rel_drop;
          if (any_req) begin
            grant_idx_next   = pick;
            grant_valid_next = 1'b1;
            hold_cnt_next    = '0;
          end else begin
            grant_valid_next = 1'b0;
            state_next       = ST_IDLE;
          end
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      default: begin
        grant_valid_next = 1'b0;
        state_next       = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= ST_IDLE;
      ptr_reg           <= '0;
      hold_cnt_reg      <= '0;
      grant_idx_reg     <= '0;
      grant_valid_reg   <= 1'b0;
      grant_expired_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      ptr_reg           <= ptr_next;
      hold_cnt_reg      <= hold_cnt_next;
      grant_idx_reg     <= grant_idx_next;
      grant_valid_reg   <= grant_valid_next;
      grant_expired_reg <= grant_expired_next;
    end
  end

  assign bus.grant_idx     = grant_idx_reg;
  assign bus.grant_valid   = grant_valid_reg;
  assign bus.grant_expired = grant_expired_reg;

endmodule
